mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory stage of the MIPS datapath, directly downstream of the execute stage. It consumes the ALU result, store data, destination register, zero flag and branch target, and resolves the branch. It performs loads and stores against an internal word-addressed data memory with a programmable access latency, stalling upstream while busy, and delivers one registered MEM/WB result per instruction.

## Interface
Parameters:
- MEM_WORDS, 256, data memory depth in 32-bit words; power of two; address uses log2(MEM_WORDS) bits.
- MEM_LATENCY, 2, busy cycles per load/store; legal range 1..15.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage accepts this cycle; equals (state == IDLE)
- stall  out  1  equals ~ex_ready; freezes PC/IF/ID/EX
- mem_read, mem_write, mem_to_reg, reg_write, branch  in  1 each  control bits
- zero_in  in  1  ALU zero flag
- alu_result  in  32  ALU output / byte address
- store_data  in  32  rt value for stores
- write_reg  in  5  destination register (post RegDest mux)
- branch_target  in  32  PC+4+(imm<<2)
- pc_src  out  1  branch taken, one-cycle pulse
- pc_target  out  32  registered branch_target
- wb_valid  out  1  one-cycle pulse per completed instruction
- wb_reg_write, wb_mem_to_reg  out  1 each  registered control
- wb_write_reg  out  5  registered destination
- wb_alu_result  out  32  registered alu_result
- wb_read_data  out  32  load data (0 for non-loads)
- misalign_err  out  1  pulses with wb_valid when a memory op had alu_result[1:0] != 0

## Operation
- Accept = ex_valid & ex_ready at a rising edge; all inputs captured into an internal EX/MEM register at that edge.
- Non-memory op (mem_read = mem_write = 0): stays IDLE; WB outputs load at the accept edge.
- Memory op: IDLE -> ACCESS at accept; down-counter loaded with MEM_LATENCY-1; decrements each cycle; at count 0 the access executes and WB outputs load at the same edge; ACCESS -> IDLE.
- Word address = captured alu_result[log2(MEM_WORDS)+1:2]; higher bits ignored (address wraps modulo MEM_WORDS).
- Misaligned memory op: store suppressed, wb_read_data = 0, misalign_err = 1; the pipeline still completes normally.
- mem_read and mem_write both set: store performed; wb_read_data = old word (read-before-write).
- Branch: pc_src = 1 for the cycle after accept iff branch & zero_in; pc_target loaded at accept. Branches never stall.
- Reset (asynchronous, any state, including mid-ACCESS): state IDLE, counter 0, all outputs 0 (ex_ready = 1, stall = 0); an in-flight store is dropped; memory contents are not cleared.

## Timing
- Accept at edge E, non-memory op: wb_valid high in the cycle after E; the next accept is possible at E+1 (throughput 1/cycle).
- Accept at edge E, memory op: ex_ready = 0 for cycles E..E+MEM_LATENCY-1; store commits and WB loads at edge E+MEM_LATENCY; wb_valid is high in the following cycle; ex_ready returns high in that same cycle.
- wb_valid, pc_src and misalign_err are single-cycle pulses; there is no downstream backpressure.
- ex_valid = 0 at an edge while IDLE: wb_valid = 0 next cycle; all other WB registers hold.

## Structure
- Shared package mips_pkg: WORD_W = 32, REG_ADDR_W = 5, state enum {IDLE, ACCESS}, MAX_MEM_LATENCY = 15.
- One sub-module, data_mem: synchronous single-port RAM, MEM_WORDS x 32, with we, addr, wdata, rdata (read-before-write), and no reset.
- FSM, counter and pipeline registers live in the top module.

## Test plan
- Reset asserted mid-ACCESS with a store pending -> all outputs 0, ex_ready = 1 immediately; the later load of that address returns the prior value.
- Store 0xDEADBEEF to 0x10, then load 0x10 with MEM_LATENCY = 2 -> stall high for 2 cycles each; wb_read_data = 0xDEADBEEF, wb_write_reg echoed.
- Three back-to-back R-type ops (alu_result 1, 2, 3) -> wb_valid on three consecutive cycles, wb_alu_result 1, 2, 3, stall never high.
- branch = 1, zero_in = 1, target 0x0040_0020 -> pc_src pulse one cycle after accept, pc_target = 0x0040_0020; with zero_in = 0 -> no pulse.
- Load from 0x13 -> misalign_err = 1, wb_read_data = 0; store to 0x402 (MEM_WORDS = 256) is dropped as misaligned; store to 0x400 lands in word 0.
- MEM_LATENCY = 1 and = 15 -> stall width is exactly 1 and 15 cycles respectively.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants used by the memory stage and its data RAM.
package mips_pkg;
  localparam int WORD_W          = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int MAX_MEM_LATENCY = 15;
  localparam int CNT_W           = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  function automatic logic is_word_aligned(input logic [1:0] byte_lsb);
    return (byte_lsb == 2'b00);
  endfunction
endpackage

// File: rtl/data_mem.sv
// Synchronous single-port word RAM; rdata returns the word held before any same-edge write.
module data_mem
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [MEM_WORDS];

  // Registered read and write share the same edge; contents survive reset.
  always_ff @(posedge clk) begin
    rdata <= mem_q[addr];
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory stage: resolves branches, performs latency-stalled loads/stores and
// delivers one registered MEM/WB result per accepted instruction.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  output logic                  stall,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  input  logic                  reg_write,
  input  logic                  branch,
  input  logic                  zero_in,
  input  logic [WORD_W-1:0]     alu_result,
  input  logic [WORD_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic [WORD_W-1:0]     branch_target,
  output logic                  pc_src,
  output logic [WORD_W-1:0]     pc_target,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [WORD_W-1:0]     wb_alu_result,
  output logic [WORD_W-1:0]     wb_read_data,
  output logic                  misalign_err
);

  localparam int              AW       = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // EX/MEM pipeline register
  logic                  exm_mr_q, exm_mr_d;
  logic                  exm_mw_q, exm_mw_d;
  logic                  exm_m2r_q, exm_m2r_d;
  logic                  exm_rw_q, exm_rw_d;
  logic [REG_ADDR_W-1:0] exm_wr_q, exm_wr_d;
  logic [WORD_W-1:0]     exm_alu_q, exm_alu_d;
  logic [WORD_W-1:0]     exm_sd_q, exm_sd_d;

  // MEM/WB pipeline register
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_rw_q, wb_rw_d;
  logic                  wb_m2r_q, wb_m2r_d;
  logic [REG_ADDR_W-1:0] wb_wr_q, wb_wr_d;
  logic [WORD_W-1:0]     wb_alu_q, wb_alu_d;
  logic [WORD_W-1:0]     wb_rd_q, wb_rd_d;
  logic                  mis_q, mis_d;
  logic                  pc_src_q, pc_src_d;
  logic [WORD_W-1:0]     pc_tgt_q, pc_tgt_d;

  logic              accept_s;
  logic              is_mem_s;
  logic              commit_s;
  logic              aligned_s;
  logic              ram_we_s;
  logic [AW-1:0]     ram_addr_s;
  logic [WORD_W-1:0] ram_rdata_s;

  assign accept_s  = ex_valid & (state_q == IDLE);
  assign is_mem_s  = mem_read | mem_write;
  assign commit_s  = (state_q == ACCESS) && (cnt_q == CNT_W'(0));
  assign aligned_s = is_word_aligned(exm_alu_q[1:0]);
  assign ram_we_s  = commit_s & exm_mw_q & aligned_s;
  // While idle the RAM reads the incoming address so the word is ready by commit, even at latency 1.
  assign ram_addr_s = (state_q == IDLE) ? alu_result[AW+1:2] : exm_alu_q[AW+1:2];

  data_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_data_mem (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (exm_sd_q),
    .rdata (ram_rdata_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CNT_W'(0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state and access countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s && is_mem_s) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_W'(0);
        end
      end
      ACCESS: begin
        if (commit_s) begin
          state_d = IDLE;
          cnt_d   = CNT_W'(0);
        end else begin
          state_d = ACCESS;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    ex_ready = (state_q == IDLE);
    stall    = (state_q != IDLE);
  end

  // EX/MEM capture on accept
  always_comb begin
    exm_mr_d  = exm_mr_q;
    exm_mw_d  = exm_mw_q;
    exm_m2r_d = exm_m2r_q;
    exm_rw_d  = exm_rw_q;
    exm_wr_d  = exm_wr_q;
    exm_alu_d = exm_alu_q;
    exm_sd_d  = exm_sd_q;
    if (accept_s) begin
      exm_mr_d  = mem_read;
      exm_mw_d  = mem_write;
      exm_m2r_d = mem_to_reg;
      exm_rw_d  = reg_write;
      exm_wr_d  = write_reg;
      exm_alu_d = alu_result;
      exm_sd_d  = store_data;
    end else begin
      exm_mr_d  = exm_mr_q;
      exm_mw_d  = exm_mw_q;
    end
  end

  // MEM/WB load: immediately for non-memory ops, at commit for memory ops
  always_comb begin
    wb_valid_d = 1'b0;
    wb_rw_d    = wb_rw_q;
    wb_m2r_d   = wb_m2r_q;
    wb_wr_d    = wb_wr_q;
    wb_alu_d   = wb_alu_q;
    wb_rd_d    = wb_rd_q;
    mis_d      = 1'b0;
    if (accept_s && !is_mem_s) begin
      wb_valid_d = 1'b1;
      wb_rw_d    = reg_write;
      wb_m2r_d   = mem_to_reg;
      wb_wr_d    = write_reg;
      wb_alu_d   = alu_result;
      wb_rd_d    = {WORD_W{1'b0}};
    end else if (commit_s) begin
      wb_valid_d = 1'b1;
      wb_rw_d    = exm_rw_q;
      wb_m2r_d   = exm_m2r_q;
      wb_wr_d    = exm_wr_q;
      wb_alu_d   = exm_alu_q;
      wb_rd_d    = (exm_mr_q && aligned_s) ? ram_rdata_s : {WORD_W{1'b0}};
      mis_d      = ~aligned_s;
    end else begin
      wb_valid_d = 1'b0;
    end
  end

  // Branch resolution
  always_comb begin
    pc_src_d = accept_s & branch & zero_in;
    if (accept_s) begin
      pc_tgt_d = branch_target;
    end else begin
      pc_tgt_d = pc_tgt_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_mr_q   <= 1'b0;
      exm_mw_q   <= 1'b0;
      exm_m2r_q  <= 1'b0;
      exm_rw_q   <= 1'b0;
      exm_wr_q   <= {REG_ADDR_W{1'b0}};
      exm_alu_q  <= {WORD_W{1'b0}};
      exm_sd_q   <= {WORD_W{1'b0}};
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
      wb_wr_q    <= {REG_ADDR_W{1'b0}};
      wb_alu_q   <= {WORD_W{1'b0}};
      wb_rd_q    <= {WORD_W{1'b0}};
      mis_q      <= 1'b0;
      pc_src_q   <= 1'b0;
      pc_tgt_q   <= {WORD_W{1'b0}};
    end else begin
      exm_mr_q   <= exm_mr_d;
      exm_mw_q   <= exm_mw_d;
      exm_m2r_q  <= exm_m2r_d;
      exm_rw_q   <= exm_rw_d;
      exm_wr_q   <= exm_wr_d;
      exm_alu_q  <= exm_alu_d;
      exm_sd_q   <= exm_sd_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_wr_q    <= wb_wr_d;
      wb_alu_q   <= wb_alu_d;
      wb_rd_q    <= wb_rd_d;
      mis_q      <= mis_d;
      pc_src_q   <= pc_src_d;
      pc_tgt_q   <= pc_tgt_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_rw_q;
  assign wb_mem_to_reg = wb_m2r_q;
  assign wb_write_reg  = wb_wr_q;
  assign wb_alu_result = wb_alu_q;
  assign wb_read_data  = wb_rd_q;
  assign misalign_err  = mis_q;
  assign pc_src        = pc_src_q;
  assign pc_target     = pc_tgt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: main instance at latency 2, plus latency 1 and 15 instances.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        mem_read, mem_write, mem_to_reg, reg_write, branch, zero_in;
  logic [31:0] alu_result, store_data, branch_target;
  logic [4:0]  write_reg;

  logic        ex_ready, stall, pc_src, wb_valid, wb_reg_write, wb_mem_to_reg, misalign_err;
  logic [31:0] pc_target, wb_alu_result, wb_read_data;
  logic [4:0]  wb_write_reg;

  logic        xv[2];
  logic        xready[2], xstall[2], xpc_src[2], xwb_valid[2], xwb_rw[2], xwb_m2r[2], xmis[2];
  logic [31:0] xpc_target[2], xwb_alu[2], xwb_rd[2];
  logic [4:0]  xwb_wr[2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem[256];

  mem_access_stage #(.MEM_WORDS(256), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .branch(branch), .zero_in(zero_in), .alu_result(alu_result), .store_data(store_data),
    .write_reg(write_reg), .branch_target(branch_target), .pc_src(pc_src), .pc_target(pc_target),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_write_reg(wb_write_reg), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .misalign_err(misalign_err)
  );

  mem_access_stage #(.MEM_WORDS(256), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(xv[0]), .ex_ready(xready[0]), .stall(xstall[0]),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .branch(branch), .zero_in(zero_in), .alu_result(alu_result), .store_data(store_data),
    .write_reg(write_reg), .branch_target(branch_target), .pc_src(xpc_src[0]), .pc_target(xpc_target[0]),
    .wb_valid(xwb_valid[0]), .wb_reg_write(xwb_rw[0]), .wb_mem_to_reg(xwb_m2r[0]),
    .wb_write_reg(xwb_wr[0]), .wb_alu_result(xwb_alu[0]), .wb_read_data(xwb_rd[0]),
    .misalign_err(xmis[0])
  );

  mem_access_stage #(.MEM_WORDS(256), .MEM_LATENCY(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .ex_valid(xv[1]), .ex_ready(xready[1]), .stall(xstall[1]),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .branch(branch), .zero_in(zero_in), .alu_result(alu_result), .store_data(store_data),
    .write_reg(write_reg), .branch_target(branch_target), .pc_src(xpc_src[1]), .pc_target(xpc_target[1]),
    .wb_valid(xwb_valid[1]), .wb_reg_write(xwb_rw[1]), .wb_mem_to_reg(xwb_m2r[1]),
    .wb_write_reg(xwb_wr[1]), .wb_alu_result(xwb_alu[1]), .wb_read_data(xwb_rd[1]),
    .misalign_err(xmis[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every wb_valid pulse of the main instance must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wb_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: wb_valid with empty scoreboard, alu=%h", wb_alu_result);
      end else begin
        e = sb.pop_front();
        if ({wb_alu_result, wb_read_data, wb_write_reg, wb_reg_write, wb_mem_to_reg, misalign_err} !==
            {e.alu, e.rd, e.wr, e.rw, e.m2r, e.mis}) begin
          errors++;
          $display("FAIL wb_result: got alu=%h rd=%h wr=%0d rw=%b m2r=%b mis=%b, expected alu=%h rd=%h wr=%0d rw=%b m2r=%b mis=%b",
                   wb_alu_result, wb_read_data, wb_write_reg, wb_reg_write, wb_mem_to_reg, misalign_err,
                   e.alu, e.rd, e.wr, e.rw, e.m2r, e.mis);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ex_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (ex_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ex_ready=%b expected 1", ex_ready);
    end
  endtask

  // Drives one instruction into the main instance and records its expected MEM/WB result
  task automatic issue(input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic br, input logic z, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] tgt, input logic [4:0] wr);
    exp_t       e;
    logic [7:0] w;
    wait_ready();
    mem_read = mr; mem_write = mw; mem_to_reg = m2r; reg_write = rw;
    branch = br; zero_in = z; alu_result = alu; store_data = sd;
    branch_target = tgt; write_reg = wr; ex_valid = 1'b1;
    w     = alu[9:2];
    e.alu = alu; e.wr = wr; e.rw = rw; e.m2r = m2r; e.rd = 32'h0;
    e.mis = (mr | mw) && (alu[1:0] != 2'b00);
    if ((mr | mw) && (alu[1:0] == 2'b00)) begin
      if (mr) e.rd = model_mem[w];
      if (mw) model_mem[w] = sd;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic count_stall(input string name, input int expected);
    int cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall === 1'b1) cnt++;
      else break;
    end
    checks++;
    if (cnt != expected) begin
      errors++;
      $display("FAIL %s: stall cycles %0d expected %0d", name, cnt, expected);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_valid = 1'b0; xv[0] = 1'b0; xv[1] = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
    branch = 1'b0; zero_in = 1'b0; alu_result = 32'h0; store_data = 32'h0;
    branch_target = 32'h0; write_reg = 5'd0;
    #3;
    checks++;
    if ({pc_src, pc_target, wb_valid, wb_reg_write, wb_mem_to_reg, wb_write_reg, wb_alu_result,
         wb_read_data, misalign_err, stall, ex_ready} !== {1'b0, 32'h0, 5'b0, 5'd0, 32'h0, 32'h0, 3'b001}) begin
      errors++;
      $display("FAIL reset_outputs: ex_ready=%b stall=%b wb_valid=%b alu=%h expected ready=1 others 0",
               ex_ready, stall, wb_valid, wb_alu_result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1 || stall !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ex_ready=%b stall=%b wb_valid=%b expected 1 0 0", ex_ready, stall, wb_valid);
    end
  endtask

  task automatic test_store_load();
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 5'd0);
    count_stall("store_stall", 2);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 5'd9);
    count_stall("load_stall", 2);
    checks++;
    if (wb_valid !== 1'b1 || wb_read_data !== 32'hDEADBEEF || wb_write_reg !== 5'd9) begin
      errors++;
      $display("FAIL load_result: valid=%b rd=%h wr=%0d expected 1 deadbeef 9", wb_valid, wb_read_data, wb_write_reg);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'(i), 32'h0, 32'h0, 5'(i + 3));
      checks++;
      if (stall !== 1'b0 || wb_valid !== 1'b1 || wb_alu_result !== 32'(i)) begin
        errors++;
        $display("FAIL b2b_%0d: stall=%b wb_valid=%b alu=%h expected 0 1 %h", i, stall, wb_valid, wb_alu_result, 32'(i));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_alu_result !== 32'd3 || wb_write_reg !== 5'd6) begin
      errors++;
      $display("FAIL idle_hold: wb_valid=%b alu=%h wr=%0d expected 0 3 6", wb_valid, wb_alu_result, wb_write_reg);
    end
  endtask

  task automatic test_branch();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0040_0020, 5'd0);
    checks++;
    if (pc_src !== 1'b1 || pc_target !== 32'h0040_0020 || stall !== 1'b0) begin
      errors++;
      $display("FAIL branch_taken: pc_src=%b target=%h stall=%b expected 1 00400020 0", pc_src, pc_target, stall);
    end
    @(posedge clk); #1;
    checks++;
    if (pc_src !== 1'b0) begin
      errors++;
      $display("FAIL branch_pulse: pc_src=%b expected 0", pc_src);
    end
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5, 32'h0, 32'h0040_0040, 5'd0);
    checks++;
    if (pc_src !== 1'b0 || pc_target !== 32'h0040_0040) begin
      errors++;
      $display("FAIL branch_not_taken: pc_src=%b target=%h expected 0 00400040", pc_src, pc_target);
    end
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 5'd2);
    count_stall("misalign_load_stall", 2);
    checks++;
    if (misalign_err !== 1'b1 || wb_read_data !== 32'h0) begin
      errors++;
      $display("FAIL misalign_load: err=%b rd=%h expected 1 0", misalign_err, wb_read_data);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1234_5678, 32'h0, 5'd0);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h402, 32'hBAD0_BAD0, 32'h0, 5'd0);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0, 5'd3);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 32'hA5A5_A5A5, 32'h0, 5'd0);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0, 5'd4);
    issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'hCAFE_F00D, 32'h0, 5'd5);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 32'h0, 5'd6);
  endtask

  task automatic test_latency(input int idx, input int lat);
    int cnt = 0;
    int n   = 0;
    while (xready[idx] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    mem_read = 1'b0; mem_write = 1'b1; alu_result = 32'h40; store_data = 32'h0BAD_F00D;
    xv[idx] = 1'b1;
    @(posedge clk); #1;
    xv[idx] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (xstall[idx] === 1'b1) cnt++;
      else break;
    end
    checks++;
    if (cnt != lat || xwb_valid[idx] !== 1'b1 || xready[idx] !== 1'b1) begin
      errors++;
      $display("FAIL latency_%0d: stall cycles %0d wb_valid=%b ready=%b expected %0d 1 1",
               lat, cnt, xwb_valid[idx], xready[idx], lat);
    end
    mem_write = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h1111_1111, 32'h0, 5'd0);
    wait_ready();
    mem_read = 1'b0; mem_write = 1'b1; alu_result = 32'h20; store_data = 32'h2222_2222;
    write_reg = 5'd0; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    mem_write = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_src, wb_valid, wb_reg_write, wb_mem_to_reg, wb_write_reg, wb_alu_result, wb_read_data,
         misalign_err, stall, ex_ready} !== {4'b0, 5'd0, 32'h0, 32'h0, 3'b001}) begin
      errors++;
      $display("FAIL reset_mid_access: ex_ready=%b stall=%b wb_valid=%b alu=%h expected ready=1 others 0",
               ex_ready, stall, wb_valid, wb_alu_result);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 5'd7);
    count_stall("post_reset_load_stall", 2);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_branch();
    test_misalign();
    test_latency(0, 1);
    test_latency(1, 15);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    test_reset_mid_access();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
